beep_sequencer: RTL and testbench



---
 rtl/beep_sequencer.sv | 123 ++++++++++++
 tb/tb_beep_sequencer.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/beep_sequencer.sv
// beep_sequencer: fixed-priority, non-preemptive buzzer sharer for three quiz event sources,
// playing each source's burst count at its own pitch with an internally generated square wave.
module beep_sequencer #(
    parameter int TICK_DIV = 100_000,
    parameter int ON_MS    = 200,
    parameter int OFF_MS   = 100,
    parameter int HALF_0   = 50_000,
    parameter int HALF_1   = 25_000,
    parameter int HALF_2   = 100_000,
    parameter int REP_0    = 3,
    parameter int REP_1    = 1,
    parameter int REP_2    = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] req,
    input  logic       mute,
    output logic       beep,
    output logic       busy,
    output logic [2:0] grant
);
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [15:0] ON_LAST  = 16'(ON_MS - 1);
    localparam logic [15:0] OFF_LAST = 16'(OFF_MS - 1);
    localparam logic [3:0] R0 = (REP_0 == 0) ? 4'd1 : 4'(REP_0);
    localparam logic [3:0] R1 = (REP_1 == 0) ? 4'd1 : 4'(REP_1);
    localparam logic [3:0] R2 = (REP_2 == 0) ? 4'd1 : 4'(REP_2);

    typedef enum logic [1:0] {IDLE, ON, OFF} state_t;

    state_t        state;
    logic [2:0]    pending, sel;
    logic [TW-1:0] tick_cnt;
    logic [15:0]   ms_cnt;
    logic [19:0]   tone_cnt, half, sel_half;
    logic [3:0]    rep_left, sel_rep;
    logic          tick_wrap, on_done, off_done;

    // Lowest pending index wins, and only while idle.
    assign sel       = (state == IDLE) ? pending & (~pending + 3'd1) : 3'd0;
    assign sel_half  = sel[0] ? 20'(HALF_0) : sel[1] ? 20'(HALF_1) : 20'(HALF_2);
    assign sel_rep   = sel[0] ? R0 : sel[1] ? R1 : R2;
    assign tick_wrap = tick_cnt == TICK_LAST;
    assign on_done   = tick_wrap && ms_cnt == ON_LAST;
    assign off_done  = tick_wrap && ms_cnt == OFF_LAST;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            pending  <= '0;
            beep     <= 1'b0;
            busy     <= 1'b0;
            grant    <= '0;
            tick_cnt <= '0;
            ms_cnt   <= '0;
            tone_cnt <= '0;
            half     <= '0;
            rep_left <= '0;
        end else if (mute) begin
            state    <= IDLE;
            pending  <= '0;
            beep     <= 1'b0;
            busy     <= 1'b0;
            grant    <= '0;
            tick_cnt <= '0;
            ms_cnt   <= '0;
            tone_cnt <= '0;
            half     <= '0;
            rep_left <= '0;
        end else begin
            pending  <= (pending & ~sel) | (req & ~grant);
            tick_cnt <= tick_wrap ? '0 : tick_cnt + 1'b1;
            ms_cnt   <= ms_cnt + {15'd0, tick_wrap};
            case (state)
                IDLE: begin
                    tick_cnt <= '0;
                    ms_cnt   <= '0;
                    tone_cnt <= '0;
                    if (sel != 3'd0) begin
                        state    <= ON;
                        grant    <= sel;
                        busy     <= 1'b1;
                        beep     <= 1'b1;
                        rep_left <= sel_rep;
                        half     <= sel_half;
                    end
                end
                ON: begin
                    if (on_done) begin
                        state    <= OFF;
                        beep     <= 1'b0;
                        tick_cnt <= '0;
                        ms_cnt   <= '0;
                        tone_cnt <= '0;
                    end else if (tone_cnt == half - 20'd1) begin
                        beep     <= ~beep;
                        tone_cnt <= '0;
                    end else begin
                        tone_cnt <= tone_cnt + 20'd1;
                    end
                end
                OFF: begin
                    if (off_done) begin
                        tick_cnt <= '0;
                        ms_cnt   <= '0;
                        tone_cnt <= '0;
                        if (rep_left > 4'd1) begin
                            rep_left <= rep_left - 4'd1;
                            state    <= ON;
                            beep     <= 1'b1;
                        end else begin
                            state <= IDLE;
                            grant <= '0;
                            busy  <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_beep_sequencer.sv
// tb_beep_sequencer: scoreboard bench for beep_sequencer with scaled-down timing;
// a pattern-level reference model predicts which source plays and the monitor checks each pattern's waveform.
module tb_beep_sequencer;
    localparam int ONC  = 40;
    localparam int OFFC = 20;
    localparam int PER  = ONC + OFFC;

    logic       clk = 1'b0;
    logic       rst;
    logic       mute;
    logic [2:0] req;
    logic       beep, busy;
    logic [2:0] grant;

    int n_tests = 0;
    int n_fail  = 0;

    beep_sequencer #(
        .TICK_DIV(10), .ON_MS(4), .OFF_MS(2),
        .HALF_0(2), .HALF_1(3), .HALF_2(5),
        .REP_0(1), .REP_1(2), .REP_2(3)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .mute(mute),
        .beep(beep), .busy(busy), .grant(grant)
    );

    always #5 clk = ~clk;

    function automatic int rep_of(input int k);
        return (k == 0) ? 1 : (k == 1) ? 2 : 3;
    endfunction

    function automatic int half_of(input int k);
        return (k == 0) ? 2 : (k == 1) ? 3 : 5;
    endfunction

    // Within each burst period the tone starts high and flips every half-period; the gap is silent.
    function automatic bit exp_beep(input int k, input int t);
        int u;
        u = t % PER;
        return (u < ONC) && (((u / half_of(k)) % 2) == 0);
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct { int src; bit gap_chk; } exp_t;
    exp_t sb[$];
    bit   sb_en = 1'b0;

    longint edge_n = 0, free_at = 0, s_edge = 0, e_edge = -1;
    int     cur = 0, m_pend = 0;
    bit     had_prev = 1'b0;

    // Reference: a pattern occupies the buzzer for rep*PER cycles, then at least one idle cycle.
    always @(posedge clk) begin : model
        int gb, sel, k;
        edge_n++;
        if (!sb_en || rst !== 1'b1 || mute) begin
            m_pend   = 0;
            free_at  = edge_n;
            had_prev = 1'b0;
            e_edge   = -1;
        end else begin
            gb  = (edge_n > s_edge && edge_n <= e_edge) ? (1 << cur) : 0;
            sel = 0;
            if (edge_n >= free_at && m_pend != 0) begin
                k   = m_pend[0] ? 0 : m_pend[1] ? 1 : 2;
                sel = 1 << k;
                sb.push_back('{src: k, gap_chk: had_prev && edge_n == free_at});
                had_prev = 1'b1;
                cur      = k;
                s_edge   = edge_n;
                e_edge   = edge_n + rep_of(k) * PER;
                free_at  = e_edge + 1;
            end
            m_pend = (m_pend & ~sel) | (int'(req) & ~gb);
        end
    end

    bit   in_pat = 1'b0;
    int   t = 0, gap = 0, bad_beep = 0, bad_grant = 0, idle_bad = 0;
    exp_t cur_e;

    always @(negedge clk) begin : monitor
        if (!sb_en || rst !== 1'b1) begin
            in_pat = 1'b0;
            gap    = 0;
        end else if (busy) begin
            if (!in_pat) begin
                in_pat    = 1'b1;
                t         = 0;
                bad_beep  = 0;
                bad_grant = 0;
                check("sb_has_entry", sb.size() > 0, 1);
                if (sb.size() > 0) cur_e = sb.pop_front();
                else cur_e = '{src: 0, gap_chk: 1'b0};
                if (cur_e.gap_chk) check("idle_gap", gap, 1);
            end
            if (grant != 3'(1 << cur_e.src)) bad_grant++;
            if (beep != exp_beep(cur_e.src, t)) bad_beep++;
            t++;
        end else begin
            if (in_pat) begin
                in_pat = 1'b0;
                check("pattern_length", t, rep_of(cur_e.src) * PER);
                check("beep_wave", bad_beep, 0);
                check("grant_onehot", bad_grant, 0);
                gap = 0;
            end
            gap++;
            if (beep || grant != 3'd0) idle_bad++;
        end
    end

    task automatic pulse(input logic [2:0] v);
        @(negedge clk);
        req = v;
        @(negedge clk);
        req = 3'd0;
    endtask

    task automatic wait_busy();
        int i;
        for (i = 0; i < 50; i++) begin
            if (busy) break;
            @(negedge clk);
        end
        check("busy_seen", i < 50, 1);
    endtask

    task automatic drain();
        int i;
        for (i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (!busy && sb.size() == 0 && m_pend == 0 && edge_n >= free_at) break;
        end
        check("drain_in_time", i < 3000, 1);
        repeat (2) @(negedge clk);
    endtask

    task automatic quiet(input string name, input int cycles);
        int bad;
        bad = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (beep || busy || grant != 3'd0) bad++;
        end
        check(name, bad, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst  = 1'b0;
        mute = 1'b0;
        req  = 3'b111;
        quiet("reset_hold_quiet", 10);
        rst = 1'b1;
        req = 3'd0;
        quiet("post_reset_quiet", 20);
        sb_en = 1'b1;

        // Latency: req in the cycle before E0, outputs after E1.
        @(negedge clk);
        req = 3'b010;
        @(posedge clk);
        #1 check("lat_e0_busy", busy, 0);
        @(negedge clk);
        req = 3'd0;
        @(posedge clk);
        #1;
        check("lat_e1_busy", busy, 1);
        check("lat_e1_grant", grant, 3'b010);
        check("lat_e1_beep", beep, 1);
        drain();

        pulse(3'b111);
        drain();

        // Same-source request is dropped; a lower-priority one queues behind.
        pulse(3'b010);
        wait_busy();
        repeat (10) @(negedge clk);
        req = 3'b010;
        @(negedge clk);
        req = 3'd0;
        repeat (9) @(negedge clk);
        req = 3'b100;
        @(negedge clk);
        req = 3'd0;
        drain();

        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            req = ($urandom_range(0, 24) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
        end
        @(negedge clk);
        req = 3'd0;
        drain();

        sb_en = 1'b0;
        pulse(3'b100);
        wait_busy();
        req = 3'b001;
        @(negedge clk);
        req = 3'd0;
        repeat (14) @(negedge clk);
        check("pre_mute_busy", busy, 1);
        mute = 1'b1;
        @(posedge clk);
        #1;
        check("mute_beep", beep, 0);
        check("mute_busy", busy, 0);
        check("mute_grant", grant, 0);
        @(negedge clk);
        mute = 1'b0;
        quiet("post_mute_silence", 300);

        pulse(3'b100);
        wait_busy();
        repeat (45) @(negedge clk);
        check("pre_rst_busy", busy, 1);
        check("pre_rst_off_beep", beep, 0);
        rst = 1'b0;
        #1;
        check("async_rst_beep", beep, 0);
        check("async_rst_busy", busy, 0);
        check("async_rst_grant", grant, 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        quiet("post_rst_silence", 300);

        sb_en = 1'b1;
        pulse(3'b001);
        drain();
        check("idle_quiet", idle_bad, 0);
        check("sb_empty_end", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
